// File: rtl/sop_pkg.sv
// Shared types and constants for the sum-of-products sweep controller.
package sop_pkg;

  localparam int VEC_W   = 4;
  localparam int TABLE_W = 16;

  // Reference truth table: r = 1 for abcd minterms 2, 4, 7, 11, 12.
  localparam logic [TABLE_W-1:0] SOP_GOLDEN = 16'h1894;
  localparam logic [VEC_W-1:0]   LAST_VEC   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sop_settle_timer.sv
// Settle counter: counts while i_inc is high and flags the last settle cycle.
// It wraps to zero on that cycle, so it is already at zero for the next vector.
module sop_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  logic [3:0] r_cnt;

  assign o_term = (r_cnt == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc) begin
      r_cnt <= o_term ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Self-test sequencer: walks all 16 abcd vectors through the external SoP datapath,
// captures r into a truth table and compares it with the golden mask.
module sop_sweep_ctrl
  import sop_pkg::*;
#(
  parameter int                 SETTLE_CYCLES = 1,
  parameter logic [TABLE_W-1:0] EXPECTED      = SOP_GOLDEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_r,
  output logic               o_a,
  output logic               o_b,
  output logic               o_c,
  output logic               o_d,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_valid,
  output logic               o_match,
  output logic [TABLE_W-1:0] o_table
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VEC_W-1:0]   r_idx;
  logic [VEC_W-1:0]   w_idx_nxt;
  logic [VEC_W-1:0]   r_vec;
  logic [TABLE_W-1:0] r_table;
  logic               r_busy;
  logic               r_done;
  logic               r_valid;
  logic               r_match;
  logic               w_term;
  logic               w_accept;
  logic               w_capture;
  logic               w_drive_vec;

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_capture   = (r_state == ST_SAMPLE) && !i_abort;
  assign w_drive_vec = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);

  sop_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr ((r_state != ST_SETTLE) || i_abort),
    .i_inc ((r_state == ST_SETTLE) && !i_abort),
    .o_term(w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SETTLE;
          w_idx_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (i_abort)     w_state_nxt = ST_IDLE;
        else if (w_term) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // The last vector ends the sweep instead of wrapping idx back to 0.
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_idx == LAST_VEC) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SETTLE;
          w_idx_nxt   = r_idx + 4'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_vec   <= w_drive_vec ? w_idx_nxt : '0;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (r_state == ST_DONE);
    end
  end

  // Capture happens on the SAMPLE edge, so the table is complete by DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_table <= '0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
    end else if (w_accept) begin
      r_table <= '0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
    end else if (w_capture) begin
      r_table[r_idx] <= i_r;
    end else if (r_state == ST_DONE) begin
      r_valid <= 1'b1;
      r_match <= (r_table == EXPECTED);
    end
  end

  assign {o_a, o_b, o_c, o_d} = r_vec;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_valid = r_valid;
  assign o_match = r_match;
  assign o_table = r_table;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Scoreboard bench for sop_sweep_ctrl: instance 0 settles 1 cycle, instance 1 settles 3.
module tb_sop_sweep_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 3;

  typedef struct {
    int          inst;
    logic [15:0] tbl;
    logic        mt;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st[2];
  logic        ab[2];
  logic        rin[2];
  logic        a[2], b[2], c[2], d[2];
  logic        busy[2], done[2], valid[2], match[2];
  logic [15:0] tbl[2];
  logic        force0 = 1'b0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   acc[2];
  bit   trk[2];
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent model of the SoP datapath: minterms 2, 4, 7, 11, 12.
  function automatic logic sop(input logic pa, input logic pb, input logic pc, input logic pd);
    return (!pa && !pb &&  pc && !pd) || (!pa &&  pb && !pc && !pd) ||
           (!pa &&  pb &&  pc &&  pd) || ( pa && !pb &&  pc &&  pd) ||
           ( pa &&  pb && !pc && !pd);
  endfunction

  assign rin[0] = sop(a[0], b[0], c[0], d[0]) | (force0 && ({a[0], b[0], c[0], d[0]} == 4'd0));
  assign rin[1] = sop(a[1], b[1], c[1], d[1]);

  sop_sweep_ctrl #(.SETTLE_CYCLES(S0), .EXPECTED(16'h1894)) dut0 (
    .clk(clk), .reset(reset), .i_start(st[0]), .i_abort(ab[0]), .i_r(rin[0]),
    .o_a(a[0]), .o_b(b[0]), .o_c(c[0]), .o_d(d[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_valid(valid[0]), .o_match(match[0]),
    .o_table(tbl[0])
  );

  sop_sweep_ctrl #(.SETTLE_CYCLES(S1), .EXPECTED(16'h1894)) dut1 (
    .clk(clk), .reset(reset), .i_start(st[1]), .i_abort(ab[1]), .i_r(rin[1]),
    .o_a(a[1]), .o_b(b[1]), .o_c(c[1]), .o_d(d[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_valid(valid[1]), .o_match(match[1]),
    .o_table(tbl[1])
  );

  function automatic int hold_of(input int i);
    return (i == 0) ? S0 + 1 : S1 + 1;
  endfunction

  function automatic logic [23:0] outs(input int i);
    return {a[i], b[i], c[i], d[i], busy[i], done[i], valid[i], match[i], tbl[i]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle vector/busy tracking and scoreboard pop on every done pulse.
  int   m_e;
  int   m_n;
  exp_t m_x;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_e = cyc - acc[i];
      m_n = 16 * hold_of(i);
      if (trk[i] && m_e >= 0) begin
        if (m_e < m_n) begin
          chk("vec_step", {28'd0, a[i], b[i], c[i], d[i]}, m_e / hold_of(i));
          chk("busy_sweep", busy[i], 1);
        end else if (m_e == m_n) begin
          chk("busy_in_done", busy[i], 1);
        end else begin
          chk("busy_after_done", busy[i], 0);
          chk("vec_after_done", {a[i], b[i], c[i], d[i]}, 0);
          trk[i] = 1'b0;
        end
      end
      if (done[i] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", i + 1, 0);
        end else begin
          m_x = sb.pop_front();
          chk("done_inst", i, m_x.inst);
          chk("done_table", tbl[i], m_x.tbl);
          chk("done_valid", valid[i], 1);
          chk("done_match", match[i], m_x.mt);
          chk("done_latency", m_e, m_x.lat);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] t, input logic m, input bit push, input bit track);
    exp_t x;
    if (push) begin
      x.inst = i;
      x.tbl  = t;
      x.mt   = m;
      x.lat  = 16 * hold_of(i) + 1;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    st[i]  = 1'b1;
    acc[i] = cyc + 1;
    trk[i] = track;
    @(posedge clk); #1;
    st[i] = 1'b0;
    chk("start_clears_valid", valid[i], 0);
    chk("start_sets_busy", busy[i], 1);
  endtask

  task automatic drain(input int i);
    repeat (16 * hold_of(i) + 4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; acc[i] = 1 << 30; trk[i] = 1'b0;
    end
    #2;
    chk("reset_outs_0", outs(0), 0);
    chk("reset_outs_1", outs(1), 0);
    #10 reset = 1'b0;

    // Full sweep, settle 1: golden table, match.
    issue(0, 16'h1894, 1'b1, 1'b1, 1'b1);
    drain(0);
    chk("valid_holds", valid[0], 1);

    // r forced high at vector 0: bit 0 set, no match.
    force0 = 1'b1;
    issue(0, 16'h1895, 1'b0, 1'b1, 1'b1);
    drain(0);
    force0 = 1'b0;
    chk("match_holds_low", match[0], 0);

    // Settle 3: each vector held 4 cycles, done at 65.
    issue(1, 16'h1894, 1'b1, 1'b1, 1'b1);
    drain(1);

    // Abort while idx 5 is settling.
    issue(0, 16'h0, 1'b0, 1'b0, 1'b0);
    wait_edge(acc[0] + 10);
    chk("abort_at_vec5", {a[0], b[0], c[0], d[0]}, 5);
    ab[0] = 1'b1;
    @(posedge clk); #1;
    ab[0] = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_vec", {a[0], b[0], c[0], d[0]}, 0);
    chk("abort_table", tbl[0], 16'h0014);
    chk("abort_valid", valid[0], 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_stays_idle", {busy[0], valid[0], match[0]}, 0);
    chk("abort_table_kept", tbl[0], 16'h0014);

    // start re-pulsed mid-sweep at idx 8 is ignored.
    issue(0, 16'h1894, 1'b1, 1'b1, 1'b1);
    wait_edge(acc[0] + 16);
    chk("repulse_at_vec8", {a[0], b[0], c[0], d[0]}, 8);
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    drain(0);

    // Asynchronous reset between edges at idx 10, then a clean sweep.
    issue(0, 16'h0, 1'b0, 1'b0, 1'b0);
    wait_edge(acc[0] + 20);
    chk("pre_reset_vec10", {a[0], b[0], c[0], d[0]}, 10);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outs_0", outs(0), 0);
    chk("async_reset_outs_1", outs(1), 0);
    #3 reset = 1'b0;
    issue(0, 16'h1894, 1'b1, 1'b1, 1'b1);
    drain(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
